// File: rtl/my_arb8way16_pkg.sv
// Shared constants, types and the round-robin index helper for the my_arb8way16 arbiter.
// The optional requester-0 priority mode is selected by the MY_ARB8WAY16_PRIO0_EN macro.
package my_arb8way16_pkg;

    localparam int N_REQ  = 8;
    localparam int DATA_W = 16;
    localparam int SEL_W  = 3;

    typedef logic [SEL_W-1:0]  idx_t;
    typedef logic [DATA_W-1:0] word_t;

    // The output stage is a single register; its occupancy is the whole FSM.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    function automatic idx_t rr_next(input idx_t idx);
        return idx + idx_t'(1);
    endfunction

endpackage

// File: rtl/my_mux8way16.sv
// 8-way 16-bit word multiplexer: out is the input selected by sel.
module my_mux8way16
    import my_arb8way16_pkg::*;
(
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic [DATA_W-1:0] in4,
    input  logic [DATA_W-1:0] in5,
    input  logic [DATA_W-1:0] in6,
    input  logic [DATA_W-1:0] in7,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] out
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        out = in0;
        case (sel)
            3'd1:    out = in1;
            3'd2:    out = in2;
            3'd3:    out = in3;
            3'd4:    out = in4;
            3'd5:    out = in5;
            3'd6:    out = in6;
            3'd7:    out = in7;
            default: out = in0;
        endcase
    end

endmodule

// File: rtl/my_arb8way16.sv
// Round-robin arbiter sharing one 8-way 16-bit mux among eight valid/ready requesters,
// with a one-entry registered output stage. Define MY_ARB8WAY16_PRIO0_EN for strict requester-0 priority.
module my_arb8way16
    import my_arb8way16_pkg::*;
#(
    parameter idx_t PTR_RESET = 3'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [DATA_W-1:0] in_data3,
    input  logic [DATA_W-1:0] in_data4,
    input  logic [DATA_W-1:0] in_data5,
    input  logic [DATA_W-1:0] in_data6,
    input  logic [DATA_W-1:0] in_data7,
    input  logic [N_REQ-1:0]  in_valid,
    output logic [N_REQ-1:0]  in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  out_src,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    state_t state_q, state_d;
    idx_t   ptr_q;
    idx_t   gnt_idx;
    logic   ptr_adv;
    logic   any_req;
    logic   load;
    logic   accept;
    word_t  mux_word;

    assign any_req = |in_valid;

    // Grant: first requesting index at or after ptr, wrapping modulo 8.
    always_comb begin
        idx_t cand;
        logic found;
        gnt_idx = ptr_q;
        ptr_adv = 1'b1;
        found   = 1'b0;
        cand    = ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr_q + idx_t'(k);
            if (!found && in_valid[cand]) begin
                gnt_idx = cand;
                found   = 1'b1;
            end
        end
`ifdef MY_ARB8WAY16_PRIO0_EN
        // Requester 0 overrides the rotation and leaves the pointer where it was.
        if (in_valid[0]) begin
            gnt_idx = '0;
            ptr_adv = 1'b0;
        end
`endif
    end

    my_mux8way16 u_mux (
        .in0 (in_data0),
        .in1 (in_data1),
        .in2 (in_data2),
        .in3 (in_data3),
        .in4 (in_data4),
        .in5 (in_data5),
        .in6 (in_data6),
        .in7 (in_data7),
        .sel (gnt_idx),
        .out (mux_word)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   state_d = any_req ? FULL : EMPTY;
            FULL:    state_d = (out_ready && !any_req) ? EMPTY : FULL;
            default: state_d = EMPTY;
        endcase
    end

    // Output logic.
    always_comb begin
        out_valid = (state_q == FULL);
        load      = !out_valid || out_ready;
        accept    = load && any_req;
        busy      = out_valid || any_req;
        in_ready  = '0;
        if (accept && !reset) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    // Output word, source tag and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= PTR_RESET;
            out_data <= '0;
            out_src  <= '0;
        end else if (accept) begin
            out_data <= mux_word;
            out_src  <= gnt_idx;
            if (ptr_adv) begin
                ptr_q <= rr_next(gnt_idx);
            end
        end
    end

endmodule

// File: tb/tb_my_arb8way16.sv
// Self-checking bench for my_arb8way16: directed scenarios plus random traffic, checked by a
// queue-based scoreboard fed from a behavioural arbitration model.
module tb_my_arb8way16;
    import my_arb8way16_pkg::*;

    localparam logic [2:0] PTR_RST = 3'd0;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  src;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] din [8];
    logic [7:0]  in_valid;
    logic [7:0]  in_ready;
    logic [15:0] out_data;
    logic [2:0]  out_src;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sbq[$];
    bit   m_valid;
    int   m_ptr;

    always #5 clk = ~clk;

    my_arb8way16 #(.PTR_RESET(PTR_RST)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data0  (din[0]),
        .in_data1  (din[1]),
        .in_data2  (din[2]),
        .in_data3  (din[3]),
        .in_data4  (din[4]),
        .in_data5  (din[5]),
        .in_data6  (din[6]),
        .in_data7  (din[7]),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every word the consumer takes must be the oldest expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_empty: got word src=%0d data=%0h expected none", out_src, out_data);
                end else begin
                    exp_t w;
                    w = sbq.pop_front();
                    check("out_data", 32'(out_data), 32'(w.data));
                    check("out_src", 32'(out_src), 32'(w.src));
                end
            end
        end
    end

    // One clock of stimulus: apply inputs, check the combinational view, advance the model.
    task automatic step(input logic [7:0] v, input bit rdy, input bit rst);
        bit          load;
        bit          any;
        bit          prio;
        int          win;
        logic [7:0]  exp_rdy;
        exp_t        w;
        @(posedge clk);
        #1;
        in_valid  = v;
        out_ready = rdy;
        reset     = rst;
        for (int i = 0; i < 8; i++) din[i] = 16'($urandom);
        #1;
        load = !m_valid || rdy;
        any  = (v != 8'h00);
        prio = 1'b0;
        win  = -1;
`ifdef MY_ARB8WAY16_PRIO0_EN
        if (v[0]) begin
            win  = 0;
            prio = 1'b1;
        end
`endif
        for (int k = 0; k < 8 && win < 0; k++) begin
            if (v[(m_ptr + k) % 8]) win = (m_ptr + k) % 8;
        end
        exp_rdy = 8'h00;
        if (load && any && !rst) exp_rdy[win] = 1'b1;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("busy", 32'(busy), 32'(m_valid || any));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (rst) begin
            m_valid = 1'b0;
            m_ptr   = int'(PTR_RST);
            sbq.delete();
        end else if (load && any) begin
            w.data = din[win];
            w.src  = 3'(win);
            sbq.push_back(w);
            m_valid = 1'b1;
            if (!prio) m_ptr = (win + 1) % 8;
        end else if (load) begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 8'h00;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) din[i] = 16'h1000 + 16'(i);
        repeat (2) @(posedge clk);
        m_valid = 1'b0;
        m_ptr   = int'(PTR_RST);

        // Idle after reset.
        repeat (3) step(8'h00, 1'b1, 1'b0);

        // All requesting with full throughput: rotation through every source.
        repeat (9) step(8'hFF, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);

        // Stall holds the word and blocks further grants.
        step(8'h84, 1'b1, 1'b0);
        repeat (3) step(8'h84, 1'b0, 1'b0);
        repeat (2) step(8'h84, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);

        // Pointer wrap from 7 back to 0.
        step(8'h00, 1'b1, 1'b1);
        step(8'h00, 1'b1, 1'b0);
        step(8'h40, 1'b1, 1'b0);
        repeat (2) step(8'h82, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);

        // Reset while a word is in flight.
        step(8'hFF, 1'b1, 1'b0);
        step(8'hFF, 1'b0, 1'b0);
        step(8'hFF, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b0);
        step(8'hFF, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);

`ifdef MY_ARB8WAY16_PRIO0_EN
        repeat (4) step(8'h0F, 1'b1, 1'b0);
        repeat (3) step(8'h0E, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
`endif

        // Random traffic with random back-pressure and occasional reset.
        for (int n = 0; n < 400; n++) begin
            logic [7:0] v;
            v = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            step(v, $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
        end
        repeat (3) step(8'h00, 1'b1, 1'b0);
        check("sb_drained", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/my_arb8way16.md
Name: my_arb8way16

Overview:
Round-robin arbiter and sequencer that shares one 8-way 16-bit mux datapath among eight valid/ready requesters. Each cycle it picks one requester and drives the 3-bit mux select from that choice. The selected word is captured into a single-entry registered output stage with its own valid/ready handshake. It sits between eight 16-bit producers and one 16-bit consumer.

Parameters:
PTR_RESET, 3'd0, round-robin pointer value after reset (the requester index checked first).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
in_data0..in_data7  input  16 each  requester data words.
in_valid  input  8  bit i high: requester i has a word.
in_ready  output  8  bit i high: requester i's word is accepted this cycle (one-hot or zero).
out_data  output  16  registered output word.
out_src  output  3  index of the requester that supplied out_data.
out_valid  output  1  out_data/out_src hold a word.
out_ready  input  1  consumer accepts the word this cycle.
busy  output  1  out_valid, or any in_valid bit set.

Behaviour:
- Reset (synchronous, active-high), sampled on the clk edge:
  - ptr <= PTR_RESET, out_valid <= 0, out_data <= 0, out_src <= 0.
  - in_ready is combinationally 0 while reset is high.
- load = !out_valid | out_ready. The output stage can take a new word this cycle, including when the current word drains in the same cycle.
- Grant (combinational): search from ptr upward, mod 8, and take the first i with in_valid[i]=1. gnt_idx is that index, any_req = |in_valid.
- sel to the mux = gnt_idx. The mux output is the selected word.
- in_ready = (load & any_req & !reset) ? onehot(gnt_idx) : 8'h00.
- On a clk edge with load & any_req:
  - out_data <= selected word, out_src <= gnt_idx, out_valid <= 1.
  - ptr <= gnt_idx + 1, 3-bit wrap: 7 -> 0.
- On a clk edge with load & !any_req: out_valid <= 0, ptr unchanged, out_data/out_src unchanged.
- On a clk edge with !load: all state held. in_ready = 0. Requesters must hold data and valid until granted.
- Latency: one cycle from acceptance to out_valid. Full throughput of one word per cycle when out_ready stays high.
- Fairness: a continuously asserting requester waits at most 7 accepted words before it is granted.
- Simultaneous drain and accept: out_valid & out_ready & any_req gives a back-to-back new word with no bubble.
- Reset mid-transfer: a pending out word is discarded, out_valid drops the next cycle, and the pointer returns to PTR_RESET.
- in_valid bits that change while not granted are legal. Arbitration is re-evaluated every cycle; there is no lock.
- States: EMPTY (out_valid=0) and FULL (out_valid=1), encoded by out_valid.
  - EMPTY -> FULL on any_req.
  - FULL -> EMPTY on out_ready & !any_req.
  - FULL -> FULL on !out_ready, or on out_ready & any_req.

Optional Feature:
Macro: MY_ARB8WAY16_PRIO0_EN.
- Defined: requester 0 has strict priority. If in_valid[0] is high and load is high, gnt_idx = 0 regardless of ptr. ptr is not advanced by a priority-0 grant. Other requesters use round-robin as above.
- Undefined: pure round-robin; requester 0 has no special treatment.

Decomposition:
- Shared package/header: N_REQ = 8, DATA_W = 16, SEL_W = 3; the function or macro for the round-robin next index (idx + 1 mod 8).
- Sub-module: instantiate the existing my_mux8way16 for the datapath select. The arbiter contains only the grant logic, pointer and output register.
- A separate my_rr_pick8 priority-encoder sub-module is optional. The default is to keep it inline.

Test Plan:
1. Reset, then all in_valid=0 -> out_valid=0, in_ready=0, busy=0. Check this for 3 cycles.
2. in_valid=8'hFF, in_dataK=16'h1000+K, out_ready=1 -> out_src sequence 0,1,...,7,0 on consecutive cycles; out_data 16'h1000..16'h1007, 16'h1000; one word per cycle.
3. in_valid=8'b1000_0100 held, out_ready=0 after first accept -> out_src=2, out_data held and in_ready=0 while stalled. After out_ready=1, next out_src=7, then 2.
4. ptr=7 (after granting 6), only in_valid[7] and in_valid[1] -> grant 7, ptr wraps to 0, then grant 1.
5. Word in flight (out_valid=1), reset asserted one cycle -> next cycle out_valid=0, and the next grant starts searching at PTR_RESET.
6. MY_ARB8WAY16_PRIO0_EN defined, in_valid=8'h0F continuous -> out_src always 0, ptr unchanged. Drop in_valid[0] -> round-robin 1,2,3 resumes.
